// File: rtl/tt_um_counter_gen.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
// A prescaler divides the enabled clock before each count step. Commands on
// ui_in[3:2] load the count, set the limit or set mode/direction. They act
// for every cycle they are held. uo_out shows either the count or a status
// word; ui_in[1] selects which one, combinationally.
module tt_um_counter_gen #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       ui_in,
  output logic [WIDTH-1:0] uo_out,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_LIMIT = 2'b10;
  localparam logic [1:0] CMD_MODE  = 2'b11;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic             cnt_en;
  logic             out_sel;
  logic [1:0]       cmd;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             halted_q, halted_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic             step;
  logic [WIDTH-1:0] step_count;
  logic             step_halt;
  logic             hold_mode;
  logic             oneshot;
  logic [WIDTH-1:0] status;

  assign cnt_en  = ui_in[0];
  assign out_sel = ui_in[1];
  assign cmd     = ui_in[3:2];

  assign term      = dir_q ? '0 : limit_q;
  assign count_inc = count_q + WIDTH'(1);
  assign count_dec = count_q - WIDTH'(1);
  assign oneshot   = (mode_q == MODE_ONESHOT);
  // Mode 3 is not listed here, so it falls through to wrap behaviour.
  assign hold_mode = (mode_q == MODE_SAT) || oneshot;

  assign step = ena && cnt_en && (cmd == CMD_NOP) && !halted_q && (pre_q == PRE_MAX);

  // Count value and halt request that a step would produce this cycle.
  always_comb begin
    step_count = count_q;
    step_halt  = 1'b0;
    if (!dir_q) begin
      if (count_q < limit_q) begin
        step_count = count_inc;
        step_halt  = oneshot && (count_inc == limit_q);
      end else if (hold_mode) begin
        step_halt = oneshot;
      end else begin
        step_count = '0;
      end
    end else begin
      if (count_q != '0) begin
        step_count = count_dec;
        step_halt  = oneshot && (count_dec == '0);
      end else if (hold_mode) begin
        step_halt = oneshot;
      end else begin
        step_count = limit_q;
      end
    end
  end

  // Next-state decode: commands take priority over counting; ena=0 freezes everything.
  always_comb begin
    count_d  = count_q;
    limit_d  = limit_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    halted_d = halted_q;
    pre_d    = pre_q;
    tc_d     = tc_q;
    if (ena) begin
      tc_d = 1'b0;
      unique case (cmd)
        CMD_NOP: begin
          if (cnt_en) begin
            // The prescaler keeps cycling while halted so it never overruns.
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
            if (step) begin
              count_d  = step_count;
              halted_d = step_halt;
              tc_d     = (step_count == term);
            end
          end
        end
        CMD_LOAD: begin
          count_d  = uio_in;
          halted_d = 1'b0;
          pre_d    = '0;
        end
        CMD_LIMIT: begin
          limit_d = uio_in;
        end
        CMD_MODE: begin
          mode_d   = uio_in[1:0];
          dir_d    = uio_in[2];
          halted_d = 1'b0;
          pre_d    = '0;
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      limit_q  <= '1;
      mode_q   <= MODE_WRAP;
      dir_q    <= 1'b0;
      halted_q <= 1'b0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      limit_q  <= limit_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      halted_q <= halted_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
    end
  end

  // Status word and output view mux.
  always_comb begin
    status    = '0;
    status[0] = dir_q;
    status[1] = halted_q;
    status[2] = tc_q;
    status[3] = (count_q == term);
    uo_out    = out_sel ? status : count_q;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_counter_gen.sv
// Directed bench for tt_um_counter_gen: a default build (PRESCALE=1) and a
// PRESCALE=3 build driven by the same stimulus.
module tb_tt_um_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] ui_in;
  logic [3:0] uio_in;
  logic [3:0] uo_out, uio_out, uio_oe;
  logic [3:0] uo_out3, uio_out3, uio_oe3;
  logic [3:0] st, st3;

  int n_checks = 0;
  int n_pass   = 0;

  // ui_in encodings: {cmd, out_sel, cnt_en}
  localparam logic [3:0] RUN   = 4'b0001;
  localparam logic [3:0] IDLE  = 4'b0000;
  localparam logic [3:0] LOAD  = 4'b0101;
  localparam logic [3:0] LIMIT = 4'b1001;
  localparam logic [3:0] MODE  = 4'b1101;

  always #5 clk = ~clk;

  tt_um_counter_gen #(.WIDTH(4), .PRESCALE(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  tt_um_counter_gen #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out3),
    .uio_in  (uio_in),
    .uio_out (uio_out3),
    .uio_oe  (uio_oe3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flip to the status view briefly, within one clock phase.
  task automatic peek(output logic [3:0] s, output logic [3:0] s3);
    ui_in[1] = 1'b1;
    #1;
    s  = uo_out;
    s3 = uo_out3;
    ui_in[1] = 1'b0;
    #1;
  endtask

  task automatic cmd(input logic [3:0] u, input logic [3:0] d);
    ui_in  = u;
    uio_in = d;
    tick();
  endtask

  initial begin
    int exp_sat[5];
    int exp_tc[5];
    int exp_dn[4];
    exp_sat = '{2, 1, 0, 0, 0};
    exp_tc  = '{0, 0, 1, 1, 1};
    exp_dn  = '{1, 0, 9, 8};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = IDLE;
    uio_in = 4'd0;
    #12;
    check("rst_count", uo_out, 0);
    check("rst_uio_out", uio_out, 0);
    check("rst_uio_oe", uio_oe, 0);
    peek(st, st3);
    check("rst_status", st, 0);

    // Wrap up through the full range.
    ui_in = RUN;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("wrap_up", uo_out, i % 16);
      if (i >= 14) begin
        peek(st, st3);
        check("wrap_up_tc", st[2], (i == 15) ? 1 : 0);
      end
    end

    // Limit 9, wrap up, then reverse direction at 2.
    cmd(LIMIT, 4'd9);
    check("set_limit_no_step", uo_out, 0);
    ui_in = RUN;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("limit9_up", uo_out, i % 10);
      if (i == 9) begin
        peek(st, st3);
        check("limit9_tc", st, 4'b1100);
      end
    end
    tick();
    tick();
    check("limit9_at2", uo_out, 2);
    cmd(MODE, 4'b0100);
    check("set_mode_no_step", uo_out, 2);
    ui_in = RUN;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_down", uo_out, exp_dn[i]);
      if (i == 1) begin
        peek(st, st3);
        check("wrap_down_tc", st, 4'b1101);
      end
    end

    // Saturate down from 3.
    cmd(MODE, 4'b0101);
    cmd(LOAD, 4'd3);
    check("sat_load", uo_out, 3);
    ui_in = RUN;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_down", uo_out, exp_sat[i]);
      peek(st, st3);
      check("sat_down_tc", st[2], exp_tc[i]);
    end

    // One-shot up to 5; held LOAD repeats harmlessly.
    cmd(MODE, 4'b0010);
    cmd(LIMIT, 4'd5);
    cmd(LOAD, 4'd0);
    tick();
    check("load_held", uo_out, 0);
    ui_in = RUN;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("oneshot_up", uo_out, (i < 5) ? i : 5);
    end
    peek(st, st3);
    check("oneshot_halted_status", st, 4'b1010);
    cmd(LOAD, 4'd2);
    check("oneshot_reload", uo_out, 2);
    peek(st, st3);
    check("oneshot_reload_status", st, 4'b0000);
    ui_in = RUN;
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("oneshot_resume", uo_out, i);
    end
    peek(st, st3);
    check("oneshot_rehalt_status", st, 4'b1110);
    tick();
    check("oneshot_stays", uo_out, 5);

    // Count to 7 then reset asynchronously mid-cycle.
    cmd(MODE, 4'b0000);
    cmd(LIMIT, 4'd15);
    cmd(LOAD, 4'd0);
    ui_in = RUN;
    for (int i = 0; i < 7; i++) tick();
    check("pre_reset_count", uo_out, 7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", uo_out, 0);
    check("async_rst_count3", uo_out3, 0);
    peek(st, st3);
    check("async_rst_status", st, 0);
    check("async_rst_status3", st3, 0);
    check("async_rst_uio_oe3", uio_oe3, 0);
    check("async_rst_uio_out3", uio_out3, 0);

    // Prescale-by-3 build, with a cnt_en pause and an ena freeze.
    ui_in = RUN;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("pre3_count", uo_out3, (i + 0) / 3);
      if (i <= 3) check("pre1_count", uo_out, i);
    end
    ui_in = IDLE;
    tick();
    tick();
    check("pre3_paused", uo_out3, 2);
    ui_in = RUN;
    tick();
    check("pre3_delayed", uo_out3, 2);
    tick();
    check("pre3_resumed", uo_out3, 3);
    check("pre1_after_pause", uo_out, 9);
    ena    = 1'b0;
    ui_in  = LOAD;
    uio_in = 4'd12;
    for (int i = 0; i < 4; i++) tick();
    check("ena_freeze3", uo_out3, 3);
    check("ena_freeze1", uo_out, 9);
    ena   = 1'b1;
    ui_in = RUN;
    tick();
    check("ena_resume_a", uo_out3, 3);
    tick();
    check("ena_resume_b", uo_out3, 3);
    tick();
    check("ena_resume_c", uo_out3, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
